// File: rtl/plab5_mcore_net_msg_to_mem_resp_pkg.sv
// Shared field layout for memory-response and network messages.
//   mem resp : { type(3) | opaque(mo) | test(2) | len(clog2(md/8)) | data(md) }
//   net msg  : { dest(ns) | src(ns) | opaque(no) | payload }
// Optional feature macro used by the adapter: PLAB5_NET_ADAPTER_STATS_EN.

`ifndef PLAB5_MCORE_NET_MSG_TO_MEM_RESP_PKG_SV
`define PLAB5_MCORE_NET_MSG_TO_MEM_RESP_PKG_SV

`define VC_MEM_RESP_MSG_LEN_NBITS(md)      ($clog2((md)/8))
`define VC_MEM_RESP_MSG_NBITS(mo,md)       (c_mem_resp_type_nbits + (mo) + c_mem_resp_test_nbits + `VC_MEM_RESP_MSG_LEN_NBITS(md) + (md))
`define VC_MEM_RESP_MSG_OPAQUE_MSB(mo,md)  (`VC_MEM_RESP_MSG_NBITS(mo,md) - c_mem_resp_type_nbits - 1)
`define VC_MEM_RESP_MSG_OPAQUE_FIELD(mo,md) `VC_MEM_RESP_MSG_OPAQUE_MSB(mo,md) -: (mo)

`define VC_NET_MSG_NBITS(p,no,ns)          ((p) + (no) + 2*(ns))
`define VC_NET_MSG_DEST_FIELD(p,no,ns)     (`VC_NET_MSG_NBITS(p,no,ns) - 1) -: (ns)
`define VC_NET_MSG_SRC_FIELD(p,no,ns)      (`VC_NET_MSG_NBITS(p,no,ns) - (ns) - 1) -: (ns)
`define VC_NET_MSG_OPAQUE_FIELD(p,no,ns)   ((p) + (no) - 1) -: (no)
`define VC_NET_MSG_PAYLOAD_FIELD(p,no,ns)  ((p) - 1) : 0

`endif

package plab5_mcore_net_msg_to_mem_resp_pkg;

  localparam int c_mem_resp_type_nbits = 3;
  localparam int c_mem_resp_test_nbits = 2;

endpackage

// File: rtl/plab5_mcore_adapter_queue2.sv
// Two-entry circular FIFO with val/rdy handshakes on both sides.
// enq_rdy depends only on registered occupancy, never on deq_rdy.

module plab5_mcore_adapter_queue2 #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sd,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic [p_nbits-1:0] entry [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               enq;
  logic               deq;
  logic               unused_sd;

  // sd labels the carried data only; it does not steer the datapath
  assign unused_sd = sd;

  // handshake decode from registered occupancy
  always_comb begin
    enq_rdy = (count < 2'd2);
    deq_val = (count > 2'd0);
    deq_msg = entry[rd_ptr];
    enq     = enq_val && enq_rdy;
    deq     = deq_val && deq_rdy;
  end

  // storage, pointers and occupancy; reset drops any buffered entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (enq) begin
        entry[wr_ptr] <= enq_msg;
        wr_ptr        <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
// Core-side receive adapter: network message -> memory response.
// Checks dest, strips the network header, clears the routing bits in the
// top of the memory opaque field, and buffers two responses.
// Optional: PLAB5_NET_ADAPTER_STATS_EN adds saturating delivered/dropped
// counters as outputs stat_delivered and stat_dropped.

module plab5_mcore_net_msg_to_mem_resp
  import plab5_mcore_net_msg_to_mem_resp_pkg::*;
#(
  parameter  int p_net_dest          = 0,
  parameter  int p_mem_opaque_nbits  = 8,
  parameter  int p_mem_data_nbits    = 32,
  parameter  int p_net_opaque_nbits  = 4,
  parameter  int p_net_srcdest_nbits = 3,
  localparam int c_mem_msg_nbits =
    `VC_MEM_RESP_MSG_NBITS(p_mem_opaque_nbits, p_mem_data_nbits),
  localparam int c_net_msg_nbits =
    `VC_NET_MSG_NBITS(c_mem_msg_nbits, p_net_opaque_nbits, p_net_srcdest_nbits)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sd,
  input  logic                       net_val,
  output logic                       net_rdy,
  input  logic [c_net_msg_nbits-1:0] net_msg,
  output logic                       mem_val,
  input  logic                       mem_rdy,
  output logic [c_mem_msg_nbits-1:0] mem_msg,
`ifdef PLAB5_NET_ADAPTER_STATS_EN
  output logic [15:0]                stat_delivered,
  output logic [15:0]                stat_dropped,
`endif
  output logic                       misroute
);

  localparam int c_mo = p_mem_opaque_nbits;
  localparam int c_md = p_mem_data_nbits;
  localparam int c_no = p_net_opaque_nbits;
  localparam int c_ns = p_net_srcdest_nbits;
  localparam logic [c_ns-1:0] c_dest = c_ns'(p_net_dest);

  logic [c_ns-1:0]            dest;
  logic [c_mem_msg_nbits-1:0] payload;
  logic                       dest_ok;
  logic                       accept;
  logic                       drop;
  logic                       enq_val;
  logic                       unused_hdr;

  // src and network opaque are not forwarded to the core
  assign unused_hdr = ^{net_msg[`VC_NET_MSG_SRC_FIELD(c_mem_msg_nbits, c_no, c_ns)],
                        net_msg[`VC_NET_MSG_OPAQUE_FIELD(c_mem_msg_nbits, c_no, c_ns)]};

  // dest check and opaque restore; routing bits live in the opaque MSBs
  always_comb begin
    dest    = net_msg[`VC_NET_MSG_DEST_FIELD(c_mem_msg_nbits, c_no, c_ns)];
    payload = net_msg[`VC_NET_MSG_PAYLOAD_FIELD(c_mem_msg_nbits, c_no, c_ns)];
    payload[`VC_MEM_RESP_MSG_OPAQUE_MSB(c_mo, c_md) -: c_ns] = '0;
    dest_ok = (dest == c_dest);
    accept  = net_val && net_rdy;
    drop    = accept && !dest_ok;
    enq_val = net_val && dest_ok;
  end

  plab5_mcore_adapter_queue2 #(
    .p_nbits (c_mem_msg_nbits)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .sd      (sd),
    .enq_val (enq_val),
    .enq_rdy (net_rdy),
    .enq_msg (payload),
    .deq_val (mem_val),
    .deq_rdy (mem_rdy),
    .deq_msg (mem_msg)
  );

  // misroute is a registered one-cycle pulse after a dropped message
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misroute <= 1'b0;
    end else begin
      misroute <= drop;
    end
  end

`ifdef PLAB5_NET_ADAPTER_STATS_EN
  // saturating delivered/dropped counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_delivered <= 16'h0000;
      stat_dropped   <= 16'h0000;
    end else begin
      if (mem_val && mem_rdy && (stat_delivered != 16'hFFFF)) begin
        stat_delivered <= stat_delivered + 16'h0001;
      end
      if (drop && (stat_dropped != 16'hFFFF)) begin
        stat_dropped <= stat_dropped + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp.sv
// Self-checking bench for plab5_mcore_net_msg_to_mem_resp (dest=2, ns=3,
// mo=8, md=32, no=4). Reference model: a queue of expected responses.

module tb_plab5_mcore_net_msg_to_mem_resp;

  localparam int MW = 47;
  localparam int NW = 57;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sd;
  logic          net_val;
  logic          net_rdy;
  logic [NW-1:0] net_msg;
  logic          mem_val;
  logic          mem_rdy;
  logic [MW-1:0] mem_msg;
  logic          misroute;
`ifdef PLAB5_NET_ADAPTER_STATS_EN
  logic [15:0]   stat_delivered;
  logic [15:0]   stat_dropped;
`endif

  int tests  = 0;
  int failed = 0;

  logic [MW-1:0] exp_q [$];
  logic          exp_mis = 1'b0;
  logic          last_acc;
  int            exp_delivered = 0;
  int            exp_dropped   = 0;

  plab5_mcore_net_msg_to_mem_resp #(
    .p_net_dest          (2),
    .p_mem_opaque_nbits  (8),
    .p_mem_data_nbits    (32),
    .p_net_opaque_nbits  (4),
    .p_net_srcdest_nbits (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sd             (sd),
    .net_val        (net_val),
    .net_rdy        (net_rdy),
    .net_msg        (net_msg),
    .mem_val        (mem_val),
    .mem_rdy        (mem_rdy),
    .mem_msg        (mem_msg),
`ifdef PLAB5_NET_ADAPTER_STATS_EN
    .stat_delivered (stat_delivered),
    .stat_dropped   (stat_dropped),
`endif
    .misroute       (misroute)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Build a network message from fields; the expected response keeps the
  // low 5 opaque bits and zeroes the 3 routing bits above them.
  task automatic mk(input logic [2:0] dest, input logic [2:0] src,
                    input logic [7:0] opq, input logic [31:0] data,
                    output logic [NW-1:0] nm, output logic [MW-1:0] em);
    logic [2:0] typ;
    logic [1:0] tst;
    logic [1:0] len;
    logic [3:0] nopq;
    typ  = 3'($urandom_range(0, 7));
    tst  = 2'($urandom_range(0, 3));
    len  = 2'($urandom_range(0, 3));
    nopq = 4'($urandom_range(0, 15));
    nm = {dest, src, nopq, typ, opq, tst, len, data};
    em = {typ, 8'(opq % 32), tst, len, data};
  endtask

  task automatic mk_rand(input logic [2:0] dest, output logic [NW-1:0] nm, output logic [MW-1:0] em);
    mk(dest, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), $urandom, nm, em);
  endtask

  // One cycle: drive at negedge, check model state, advance model at posedge.
  task automatic step(input logic nv, input logic [NW-1:0] nm, input logic [MW-1:0] em, input logic mr);
    logic acc, deq;
    net_val = nv;
    net_msg = nm;
    mem_rdy = mr;
    #1;
    check("net_rdy", 64'(net_rdy), 64'(exp_q.size() < 2));
    check("mem_val", 64'(mem_val), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("mem_msg", 64'(mem_msg), 64'(exp_q[0]));
    check("misroute", 64'(misroute), 64'(exp_mis));
`ifdef PLAB5_NET_ADAPTER_STATS_EN
    check("stat_delivered", 64'(stat_delivered), 64'(exp_delivered));
    check("stat_dropped", 64'(stat_dropped), 64'(exp_dropped));
`endif
    acc = nv && (exp_q.size() < 2);
    deq = mr && (exp_q.size() > 0);
    @(posedge clk);
    if (deq) begin
      void'(exp_q.pop_front());
      if (exp_delivered < 65535) exp_delivered++;
    end
    exp_mis = acc && (nm[NW-1 -: 3] != 3'd2);
    if (exp_mis && exp_dropped < 65535) exp_dropped++;
    if (acc && nm[NW-1 -: 3] == 3'd2) exp_q.push_back(em);
    last_acc = acc;
    @(negedge clk);
  endtask

  initial begin
    logic [NW-1:0] nm, nm3;
    logic [MW-1:0] em, em3;
    int guard;

    reset_n = 1'b0;
    sd      = 1'b0;
    net_val = 1'b0;
    net_msg = '0;
    mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_val", 64'(mem_val), 64'd0);
    check("rst_net_rdy", 64'(net_rdy), 64'd1);
    check("rst_misroute", 64'(misroute), 64'd0);
    check("rst_mem_msg", 64'(mem_msg), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single delivery
    mk(3'd2, 3'd0, 8'h45, 32'hDEADBEEF, nm, em);
    step(1'b1, nm, em, 1'b1);
    check("t1_opaque", 64'(mem_msg[43:36]), 64'h05);
    check("t1_data", 64'(mem_msg[31:0]), 64'hDEADBEEF);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // backpressure: two accepted, third held until space frees
    mk_rand(3'd2, nm, em);
    step(1'b1, nm, em, 1'b0);
    mk_rand(3'd2, nm, em);
    step(1'b1, nm, em, 1'b0);
    mk_rand(3'd2, nm3, em3);
    step(1'b1, nm3, em3, 1'b0);
    step(1'b1, nm3, em3, 1'b0);
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 10) begin
      step(1'b1, nm3, em3, 1'b1);
      guard++;
    end
    check("t2_third_accepted", 64'(last_acc), 64'd1);
    repeat (4) step(1'b0, '0, '0, 1'b1);

    // streaming
    for (int i = 0; i < 100; i++) begin
      mk_rand(3'd2, nm, em);
      step(1'b1, nm, em, 1'b1);
    end
    repeat (3) step(1'b0, '0, '0, 1'b1);

    // misroute
    mk_rand(3'd5, nm, em);
    step(1'b1, nm, em, 1'b1);
    check("t4_consumed", 64'(last_acc), 64'd1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // asynchronous reset mid-operation with two entries buffered
    mk_rand(3'd2, nm, em);
    step(1'b1, nm, em, 1'b0);
    mk_rand(3'd2, nm, em);
    step(1'b1, nm, em, 1'b0);
    net_val = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_mem_val", 64'(mem_val), 64'd0);
    check("t5_net_rdy", 64'(net_rdy), 64'd1);
    exp_q.delete();
    exp_mis = 1'b0;
    exp_delivered = 0;
    exp_dropped = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    mk_rand(3'd2, nm, em);
    step(1'b1, nm, em, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // randomized mix: valid, ready and dest all vary
    for (int i = 0; i < 300; i++) begin
      mk_rand(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2, nm, em);
      step(1'($urandom_range(0, 1)), nm, em, ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, '0, '0, 1'b1);

`ifdef PLAB5_NET_ADAPTER_STATS_EN
    // saturation of the delivered counter
    mk_rand(3'd2, nm, em);
    net_val = 1'b1;
    net_msg = nm;
    mem_rdy = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("t6_stat_delivered_sat", 64'(stat_delivered), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
